// File: rtl/axis_video_src.sv
// axis_video_src: AXI4-Stream test-pattern video master (counter, colour bars, grey ramp, solid)
// framing each frame with tuser at SOF, tlast at end of line, and an idle gap between frames.
module axis_video_src #(
    parameter int H_ACTIVE   = 480,
    parameter int V_ACTIVE   = 272,
    parameter int GAP_CYCLES = 16
) (
    input  logic        axis_aclk,
    input  logic        axis_aresetn,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic [31:0] axis_tdata,
    output logic        axis_tvalid,
    input  logic        axis_tready,
    output logic        axis_tuser,
    output logic        axis_tlast,
    output logic [3:0]  axis_tstrb,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] BW_LAST  = 16'(H_ACTIVE / 8 - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d, bw_q, bw_d, gap_q, gap_d, frame_cnt_q, frame_cnt_d;
    logic [2:0]  bar_q, bar_d;
    logic [31:0] pix_q, pix_d, tdata_q, tdata_d;
    logic [1:0]  mode_q, mode_d;
    logic [23:0] rgb_q, rgb_d;
    logic        tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d, done_q, done_d;
    logic        eol, last, launch;

    function automatic logic [31:0] pixel(input logic [1:0] m, input logic [23:0] rgb,
                                          input logic [31:0] p, input logic [7:0] xx,
                                          input logic [2:0] b);
        return m == 2'd0 ? p : {8'h00, m == 2'd1 ? BARS[b] : m == 2'd2 ? {3{xx}} : rgb};
    endfunction

    always_comb begin
        eol         = x_q == X_LAST;
        last        = eol && y_q == Y_LAST;
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        bw_d        = bw_q;
        bar_d       = bar_q;
        pix_d       = pix_q;
        gap_d       = gap_q;
        mode_d      = mode_q;
        rgb_d       = rgb_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tuser_d     = tuser_q;
        tlast_d     = tlast_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        launch      = state_q == IDLE && enable;
        // In SEND tvalid is always high, so tready alone marks an accepted beat.
        if (state_q == SEND && axis_tready) begin
            if (last) begin
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                tvalid_d    = 1'b0;
                tuser_d     = 1'b0;
                tlast_d     = 1'b0;
                tdata_d     = '0;
                gap_d       = '0;
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                    launch  = enable;
                end else begin
                    state_d = GAP;
                end
            end else begin
                x_d     = eol ? '0 : x_q + 16'd1;
                y_d     = eol ? y_q + 16'd1 : y_q;
                bw_d    = (eol || bw_q == BW_LAST) ? '0 : bw_q + 16'd1;
                bar_d   = eol ? '0 : bw_q == BW_LAST ? bar_q + 3'd1 : bar_q;
                pix_d   = pix_q + 32'd1;
                tuser_d = 1'b0;
                tlast_d = x_d == X_LAST;
                tdata_d = pixel(mode_q, rgb_q, pix_d, x_d[7:0], bar_d);
            end
        end
        if (state_q == GAP) begin
            gap_d = gap_q + 16'd1;
            if (gap_q == GAP_LAST) state_d = IDLE;
        end
        if (launch) begin
            state_d  = SEND;
            x_d      = '0;
            y_d      = '0;
            bw_d     = '0;
            bar_d    = '0;
            pix_d    = '0;
            mode_d   = mode;
            rgb_d    = solid_rgb;
            tvalid_d = 1'b1;
            tuser_d  = 1'b1;
            tlast_d  = 1'b0;
            tdata_d  = pixel(mode, solid_rgb, '0, '0, '0);
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            bw_q        <= '0;
            bar_q       <= '0;
            pix_q       <= '0;
            gap_q       <= '0;
            mode_q      <= '0;
            rgb_q       <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            bw_q        <= bw_d;
            bar_q       <= bar_d;
            pix_q       <= pix_d;
            gap_q       <= gap_d;
            mode_q      <= mode_d;
            rgb_q       <= rgb_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tuser_q     <= tuser_d;
            tlast_q     <= tlast_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign axis_tdata  = tdata_q;
    assign axis_tvalid = tvalid_q;
    assign axis_tuser  = tuser_q;
    assign axis_tlast  = tlast_q;
    assign axis_tstrb  = {4{tvalid_q}};
    assign frame_done  = done_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_axis_video_src.sv
// tb_axis_video_src: directed checks of framing, patterns, backpressure, reset and back-to-back frames.
module tb_axis_video_src;
    localparam int H = 16;
    localparam int V = 4;
    localparam int G = 3;
    localparam int N = H * V;

    logic        clk = 0, rst_n = 1, enable = 0, tready = 0, en2 = 0, tready2 = 0;
    logic [1:0]  mode = 0, mode2 = 0;
    logic [23:0] solid = 0;
    logic [31:0] tdata, tdata2;
    logic        tvalid, tuser, tlast, done, tvalid2, tuser2, tlast2, done2;
    logic [3:0]  tstrb, tstrb2;
    logic [15:0] fcnt, fcnt2;
    int          checks = 0, errors = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk = ~clk;

    axis_video_src #(.H_ACTIVE(H), .V_ACTIVE(V), .GAP_CYCLES(G)) dut (
        .axis_aclk(clk), .axis_aresetn(rst_n), .enable(enable), .mode(mode), .solid_rgb(solid),
        .axis_tdata(tdata), .axis_tvalid(tvalid), .axis_tready(tready), .axis_tuser(tuser),
        .axis_tlast(tlast), .axis_tstrb(tstrb), .frame_done(done), .frame_cnt(fcnt));

    axis_video_src #(.H_ACTIVE(H), .V_ACTIVE(V), .GAP_CYCLES(0)) dut2 (
        .axis_aclk(clk), .axis_aresetn(rst_n), .enable(en2), .mode(mode2), .solid_rgb(solid),
        .axis_tdata(tdata2), .axis_tvalid(tvalid2), .axis_tready(tready2), .axis_tuser(tuser2),
        .axis_tlast(tlast2), .axis_tstrb(tstrb2), .frame_done(done2), .frame_cnt(fcnt2));

    task automatic drain();
        int c = 0;
        tready = 1;
        enable = 0;
        while (done !== 1'b1 && c < 500) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL drain_timeout frame_done got %b exp 1", done); end
        repeat (G + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #2;
        checks++;
        if ({tvalid, tuser, tlast, tdata, tstrb, done, fcnt} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {tvalid, tuser, tlast, tdata, tstrb, done, fcnt});
        end
        checks++;
        if ({tvalid2, tuser2, tlast2, tdata2, tstrb2, done2, fcnt2} !== '0) begin
            errors++; $display("FAIL reset_outputs2 got %h exp 0", {tvalid2, tuser2, tlast2, tdata2, tstrb2, done2, fcnt2});
        end
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || tstrb !== 4'h0) begin errors++; $display("FAIL idle_no_enable tvalid got %b exp 0", tvalid); end
    endtask

    task automatic test_counter();
        int e = 0, zeros = 1;
        mode = 0; tready = 1; enable = 1;
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tuser !== 1'b1 || tdata !== 32'd0) begin
            errors++; $display("FAIL sof_latency got v=%b u=%b d=%h exp v=1 u=1 d=0", tvalid, tuser, tdata);
        end
        for (int c = 0; c < 200 && e < N; c++) begin
            if (tvalid === 1'b1) begin
                checks++;
                if (tdata !== 32'(e) || tuser !== (e == 0) || tlast !== (e % H == H - 1) || tstrb !== 4'hF) begin
                    errors++; $display("FAIL cnt_beat got d=%h u=%b l=%b s=%h exp d=%h", tdata, tuser, tlast, tstrb, e);
                end
                e++;
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || fcnt !== 16'd1 || tvalid !== 1'b0) begin
            errors++; $display("FAIL cnt_done got done=%b cnt=%0d v=%b exp 1 1 0 (beats %0d)", done, fcnt, tvalid, e);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_once got %b exp 0", done); end
        while (tvalid !== 1'b1 && zeros < 20) begin
            zeros++;
            @(negedge clk);
        end
        checks++;
        if (zeros != G + 1 || tuser !== 1'b1 || tdata !== 32'd0) begin
            errors++; $display("FAIL gap_len got %0d idle cycles u=%b exp %0d u=1", zeros, tuser, G + 1);
        end
        drain();
        checks++;
        if (fcnt !== 16'd2) begin errors++; $display("FAIL cnt_frames got %0d exp 2", fcnt); end
    endtask

    task automatic test_backpressure();
        int e = 0;
        logic pv = 0, pr = 0;
        logic [38:0] prev = '0, cur;
        mode = 0; enable = 1; tready = 0;
        for (int c = 0; c < 1000 && e < N; c++) begin
            @(negedge clk);
            cur = {tvalid, tuser, tlast, tstrb, tdata};
            if (pv && !pr) begin
                checks++;
                if (cur !== prev) begin errors++; $display("FAIL bp_stable got %h exp %h", cur, prev); end
            end
            if (e > 0) begin
                checks++;
                if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_valid_drop got %b exp 1 at beat %0d", tvalid, e); end
            end
            if (tvalid === 1'b1) enable = 0;
            tready = 1'($urandom_range(0, 1));
            if (tvalid === 1'b1 && tready) begin
                checks++;
                if (tdata !== 32'(e) || tuser !== (e == 0) || tlast !== (e % H == H - 1)) begin
                    errors++; $display("FAIL bp_beat got d=%h u=%b l=%b exp d=%h", tdata, tuser, tlast, e);
                end
                e++;
            end
            prev = cur; pv = tvalid; pr = tready;
        end
        checks++;
        if (e != N) begin errors++; $display("FAIL bp_timeout got %0d beats exp %0d", e, N); end
        drain();
    endtask

    task automatic test_colour_bars();
        int e = 0;
        mode = 1; tready = 1; enable = 1;
        @(negedge clk);
        for (int c = 0; c < 200 && e < N; c++) begin
            if (tvalid === 1'b1) begin
                enable = 0;
                checks++;
                if (tdata !== {8'h00, bars[(e % H) / 2]} || tuser !== (e == 0)) begin
                    errors++; $display("FAIL bars got %h exp %h at beat %0d", tdata, {8'h00, bars[(e % H) / 2]}, e);
                end
                e++;
            end
            @(negedge clk);
        end
        checks++;
        if (e != N) begin errors++; $display("FAIL bars_timeout got %0d beats exp %0d", e, N); end
        drain();
    endtask

    task automatic test_enable_mode();
        int e = 0;
        mode = 2; solid = 24'h0F0F0F; tready = 1; enable = 1;
        @(negedge clk);
        for (int c = 0; c < 200 && e < N; c++) begin
            if (tvalid === 1'b1) begin
                if (e == 20) begin enable = 0; mode = 3; end
                checks++;
                if (tdata !== {8'h00, {3{8'(e % H)}}}) begin
                    errors++; $display("FAIL grey got %h exp %h at beat %0d", tdata, {8'h00, {3{8'(e % H)}}}, e);
                end
                e++;
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || e != N) begin errors++; $display("FAIL grey_done got done=%b beats=%0d exp 1 %0d", done, e, N); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (tvalid !== 1'b0) begin errors++; $display("FAIL no_sof_disabled got %b exp 0", tvalid); end
        end
        solid = 24'h12A5C3; enable = 1; e = 0;
        @(negedge clk);
        for (int c = 0; c < 200 && e < N; c++) begin
            if (tvalid === 1'b1) begin
                enable = 0;
                if (e == 10) solid = 24'hFFFFFF;
                checks++;
                if (tdata !== 32'h0012A5C3 || tuser !== (e == 0)) begin
                    errors++; $display("FAIL solid got %h u=%b exp 0012a5c3 at beat %0d", tdata, tuser, e);
                end
                e++;
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int e = 0;
        logic hit = 0;
        mode = 0; tready = 1; enable = 1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (tvalid === 1'b1) begin
                if (e == 37) hit = 1;
                else e++;
            end
        end
        checks++;
        if (tdata !== 32'd37 || fcnt !== 16'd6) begin errors++; $display("FAIL pre_reset got d=%h cnt=%0d exp 25 6", tdata, fcnt); end
        rst_n = 0;
        #1;
        checks++;
        if ({tvalid, tuser, tlast, tdata, tstrb, done, fcnt} !== '0) begin
            errors++; $display("FAIL mid_reset got %h exp 0", {tvalid, tuser, tlast, tdata, tstrb, done, fcnt});
        end
        @(negedge clk);
        checks++;
        if ({tvalid, tdata, fcnt} !== '0) begin errors++; $display("FAIL reset_hold got %h exp 0", {tvalid, tdata, fcnt}); end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tuser !== 1'b1 || tdata !== 32'd0 || fcnt !== 16'd0) begin
            errors++; $display("FAIL restart got v=%b u=%b d=%h cnt=%0d exp 1 1 0 0", tvalid, tuser, tdata, fcnt);
        end
        drain();
        checks++;
        if (fcnt !== 16'd1) begin errors++; $display("FAIL restart_cnt got %0d exp 1", fcnt); end
    endtask

    task automatic test_back_to_back();
        int e = 0;
        mode2 = 0; tready2 = 1; en2 = 1;
        @(negedge clk);
        for (int c = 0; c < 3 * N; c++) begin
            checks++;
            if (tvalid2 !== 1'b1 || tdata2 !== 32'(e % N) || tuser2 !== (e % N == 0) || tlast2 !== (e % H == H - 1)) begin
                errors++; $display("FAIL b2b_beat got v=%b d=%h u=%b l=%b exp d=%h", tvalid2, tdata2, tuser2, tlast2, e % N);
            end
            if (e > 0 && e % N == 0) begin
                checks++;
                if (done2 !== 1'b1 || fcnt2 !== 16'(e / N)) begin
                    errors++; $display("FAIL b2b_done got done=%b cnt=%0d exp 1 %0d", done2, fcnt2, e / N);
                end
            end
            if (e == 2 * N + 5) en2 = 0;
            e++;
            @(negedge clk);
        end
        checks++;
        if (done2 !== 1'b1 || fcnt2 !== 16'd3 || tvalid2 !== 1'b0) begin
            errors++; $display("FAIL b2b_end got done=%b cnt=%0d v=%b exp 1 3 0", done2, fcnt2, tvalid2);
        end
        force dut2.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut2.frame_cnt_q;
        en2 = 1; e = 0;
        @(negedge clk);
        for (int c = 0; c < 200 && e < N; c++) begin
            if (tvalid2 === 1'b1) begin
                en2 = 0;
                e++;
            end
            @(negedge clk);
        end
        checks++;
        if (done2 !== 1'b1 || fcnt2 !== 16'd0) begin errors++; $display("FAIL cnt_wrap got done=%b cnt=%h exp 1 0000", done2, fcnt2); end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_backpressure();
        test_colour_bars();
        test_enable_mode();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
